// File: rtl/audio_mixer_seq.sv
// Sequential volume-weighted audio mixer: one shared multiplier, one channel per cycle.
// Optional macro AUDIO_MIXER_SATURATE_EN clamps the mix instead of wrapping it.
module audio_mixer_seq #(
  parameter int NUM_CHANNELS = 3,
  parameter int IN_WIDTH     = 9,
  parameter int VOL_WIDTH    = 4,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_sample_stb,
  input  logic [NUM_CHANNELS*IN_WIDTH-1:0]  i_channels,
  input  logic [NUM_CHANNELS*VOL_WIDTH-1:0] i_volumes,
  output logic [OUT_WIDTH-1:0]              o_sample,
  output logic                              o_sample_stb,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ACC_W  = IN_WIDTH + VOL_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_W = IN_WIDTH + VOL_WIDTH;
  localparam int EXT_W  = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IN_WIDTH-1:0]   ch_q  [NUM_CHANNELS];
  logic [IN_WIDTH-1:0]   ch_d  [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]  vol_q [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]  vol_d [NUM_CHANNELS];
  logic [IN_WIDTH-1:0]   ch_in [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]  vol_in[NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]  sample_q, sample_d;
  logic                  stb_q, stb_d;
  logic                  overrun_q, overrun_d;

  logic [PROD_W-1:0]     prod;
  logic [ACC_W-1:0]      acc_sum;
  logic [EXT_W-1:0]      mix_ext;
  logic [OUT_WIDTH-1:0]  mix_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
      assign ch_in[gi]  = i_channels[gi*IN_WIDTH +: IN_WIDTH];
      assign vol_in[gi] = i_volumes[gi*VOL_WIDTH +: VOL_WIDTH];
    end
  endgenerate

  // Shared multiplier datapath; the final sum feeds the output directly so
  // o_sample and its strobe both appear in the DONE cycle.
  always_comb begin
    prod    = ch_q[idx_q] * vol_q[idx_q];
    acc_sum = acc_q + ACC_W'(prod);
    mix_ext = EXT_W'(acc_sum) >> VOL_WIDTH;
`ifdef AUDIO_MIXER_SATURATE_EN
    mix_out = (mix_ext > EXT_W'(OUT_MAX)) ? OUT_MAX : mix_ext[OUT_WIDTH-1:0];
`else
    mix_out = mix_ext[OUT_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    ch_d      = ch_q;
    vol_d     = vol_q;
    sample_d  = sample_q;
    stb_d     = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (i_sample_stb) begin
          ch_d    = ch_in;
          vol_d   = vol_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          sample_d = mix_out;
          stb_d    = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (i_sample_stb && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      ch_q      <= '{default: '0};
      vol_q     <= '{default: '0};
      sample_q  <= '0;
      stb_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      ch_q      <= ch_d;
      vol_q     <= vol_d;
      sample_q  <= sample_d;
      stb_q     <= stb_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_sample_stb = stb_q;
  assign o_busy       = (state_q != IDLE);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Scoreboard bench for audio_mixer_seq: expected mixes are queued at strobe time
// and matched, value and cycle, against each o_sample_stb pulse.
module tb_audio_mixer_seq;
  localparam int NC = 3;
  localparam int IW = 9;
  localparam int VW = 4;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_sample_stb = 1'b0;
  logic [NC*IW-1:0] i_channels = '0;
  logic [NC*VW-1:0] i_volumes = '0;
  logic [OW-1:0]   o_sample;
  logic            o_sample_stb;
  logic            o_busy;
  logic            o_overrun;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  audio_mixer_seq #(
    .NUM_CHANNELS(NC), .IN_WIDTH(IW), .VOL_WIDTH(VW), .OUT_WIDTH(OW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_sample_stb(i_sample_stb),
    .i_channels(i_channels), .i_volumes(i_volumes),
    .o_sample(o_sample), .o_sample_stb(o_sample_stb),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int model(input logic [NC*IW-1:0] ch, input logic [NC*VW-1:0] vol);
    int s = 0;
    for (int k = 0; k < NC; k++) s += int'(ch[k*IW +: IW]) * int'(vol[k*VW +: VW]);
    s = s >> VW;
`ifdef AUDIO_MIXER_SATURATE_EN
    if (s > 255) s = 255;
`else
    s = s & 255;
`endif
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe is high during the current cycle T; result is due in cycle T+NC+1.
  task automatic send(input logic [NC*IW-1:0] ch, input logic [NC*VW-1:0] vol, input bit expect_out);
    exp_t e;
    i_channels   = ch;
    i_volumes    = vol;
    i_sample_stb = 1'b1;
    e.val = model(ch, vol);
    e.cyc = cyc + NC + 1;
    if (expect_out) sb.push_back(e);
    $display("strobe at cycle %0d ch=%h vol=%h expect=%0d", cyc, ch, vol, e.val);
    tick(1);
    i_sample_stb = 1'b0;
  endtask

  localparam logic [NC*IW-1:0] CH_A   = {9'd30, 9'd50, 9'd100};
  localparam logic [NC*IW-1:0] CH_MAX = {9'd511, 9'd511, 9'd511};
  localparam logic [NC*VW-1:0] VOL_F  = {4'd15, 4'd15, 4'd15};
  localparam logic [NC*VW-1:0] VOL_0  = {4'd0, 4'd0, 4'd0};

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (o_sample_stb) begin
          if (sb.size() == 0) begin
            check("unexpected_stb", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("output at cycle %0d sample=%0d expect=%0d", cyc, o_sample, e.val);
            check("sample", int'(o_sample), e.val);
            check("stb_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset state
    tick(2);
    check("rst_sample", int'(o_sample), 0);
    check("rst_stb", int'(o_sample_stb), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_overrun", int'(o_overrun), 0);
    i_rst = 1'b0;
    tick(1);

    // Basic mix 100/50/30 at full volume -> 168 in cycle T+4
    send(CH_A, VOL_F, 1'b1);
    check("busy_accum", int'(o_busy), 1);
    tick(3);
    check("mix_168", int'(o_sample), 168);
    check("busy_done", int'(o_busy), 1);
    tick(1);
    check("stb_low_after", int'(o_sample_stb), 0);
    check("busy_idle", int'(o_busy), 0);
    check("hold_sample", int'(o_sample), 168);
    tick(1);

    // Overflow: wrap (157) or clamp (255)
    send(CH_MAX, VOL_F, 1'b1);
    tick(NC + 1);
`ifdef AUDIO_MIXER_SATURATE_EN
    check("overflow_sat", int'(o_sample), 255);
`else
    check("overflow_wrap", int'(o_sample), 157);
`endif
    tick(1);

    // Zero volume
    send(CH_MAX, VOL_0, 1'b1);
    tick(NC + 1);
    check("vol_zero", int'(o_sample), 0);
    tick(1);

    // Input change after the snapshot cycle is ignored
    send(CH_A, VOL_F, 1'b1);
    i_channels = CH_MAX;
    i_volumes  = VOL_0;
    tick(NC);
    check("snapshot_168", int'(o_sample), 168);
    tick(2);

    // Back-to-back at T and T+5
    send(CH_A, VOL_F, 1'b1);
    tick(NC + 1);
    send(CH_MAX, VOL_F, 1'b1);
    tick(NC + 2);
    check("b2b_no_overrun", int'(o_overrun), 0);

    // Overrun: second strobe at T+2 is ignored
    send(CH_A, VOL_F, 1'b1);
    tick(1);
    i_channels   = CH_MAX;
    i_sample_stb = 1'b1;
    tick(1);
    i_sample_stb = 1'b0;
    check("overrun_set", int'(o_overrun), 1);
    tick(1);
    check("overrun_result", int'(o_sample), 168);
    tick(4);
    check("overrun_sticky", int'(o_overrun), 1);

    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check("overrun_cleared", int'(o_overrun), 0);
    tick(1);

    // Reset mid-mix at T+2: result dropped
    send(CH_A, VOL_F, 1'b1);
    tick(1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    sb.delete();
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_sample", int'(o_sample), 0);
    check("midrst_stb", int'(o_sample_stb), 0);
    tick(4);
    send(CH_A, VOL_F, 1'b1);
    tick(NC);
    check("after_rst_mix", int'(o_sample), 168);
    tick(3);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
